// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage between the PC and instruction memory
//
// Samples the PC on a fetch request, runs one valid/ready request to
// instruction memory, waits up to TIMEOUT cycles for the response and
// latches it into the instruction register. disablepc is low only in the
// single DONE cycle, so the PC advances exactly once per successful fetch.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   fetch_req                      start a fetch (sampled in IDLE only)
//   pc_addr                        current PC value
//   disablepc                      1 = PC holds, 0 = PC loads
//   imem_req_valid/ready/addr      request channel to instruction memory
//   imem_rsp_valid/data            response channel from instruction memory
//   ir, ir_valid                   instruction register and its update pulse
//   fetch_err                      pulse on misaligned address or timeout
//   busy                           fetch in progress (state != IDLE)

module instr_fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              disablepc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              fetch_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] ir_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_req) begin
                        addr_q <= pc_addr;
                        // Misaligned fetches never reach memory.
                        if (pc_addr[1:0] != 2'b00) begin
                            state_q <= ST_ERR;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (imem_req_ready) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    // A response on the last allowed cycle beats the timeout.
                    if (imem_rsp_valid) begin
                        ir_q    <= imem_rsp_data;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so they are glitch-free
    // with respect to the inputs.
    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = addr_q;
    assign ir             = ir_q;
    assign ir_valid       = (state_q == ST_DONE);
    assign fetch_err      = (state_q == ST_ERR);
    assign disablepc      = (state_q != ST_DONE);
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        disablepc;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic        fetch_err;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .pc_addr        (pc_addr),
        .disablepc      (disablepc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ir             (ir),
        .ir_valid       (ir_valid),
        .fetch_err      (fetch_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, disablepc, imem_req_valid, ir_valid, fetch_err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 01000", {busy, disablepc, imem_req_valid, ir_valid, fetch_err});
        end
        n_checks++;
        if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h expected 00000000", ir); end
        cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        pc_addr = 32'h10; fetch_req = 1'b1; imem_req_ready = 1'b1;
        cyc();                              // sampled in IDLE -> REQ
        fetch_req = 1'b0;
        n_checks++;
        if ({imem_req_valid, busy, disablepc} !== 3'b111 || imem_req_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL basic_req: got v/b/d=%b addr=%h expected 111 addr=00000010", {imem_req_valid, busy, disablepc}, imem_req_addr);
        end
        cyc();                              // accepted -> WAIT
        n_checks++;
        if (imem_req_valid !== 1'b0 || ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_wait: got req_valid=%b ir_valid=%b expected 0 0", imem_req_valid, ir_valid);
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
        cyc();                              // -> DONE, third cycle
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (ir !== 32'hDEADBEEF || ir_valid !== 1'b1 || disablepc !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: got ir=%h iv=%b dpc=%b expected deadbeef 1 0", ir, ir_valid, disablepc);
        end
        cyc();
        n_checks++;
        if (ir_valid !== 1'b0 || disablepc !== 1'b1 || busy !== 1'b0 || ir !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL basic_after: got iv=%b dpc=%b busy=%b ir=%h expected 0 1 0 deadbeef", ir_valid, disablepc, busy, ir);
        end
    endtask

    task automatic test_backpressure();
        pc_addr = 32'h20; fetch_req = 1'b1; imem_req_ready = 1'b0;
        cyc();
        fetch_req = 1'b0; pc_addr = 32'h44;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b addr=%h expected 1 00000020", i, imem_req_valid, imem_req_addr);
            end
            cyc();
        end
        imem_req_ready = 1'b1;
        n_checks++;
        if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold4: got %b expected 1", imem_req_valid); end
        cyc();                              // -> WAIT
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
        cyc();
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (ir !== 32'h12345678 || ir_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_done: got ir=%h iv=%b expected 12345678 1", ir, ir_valid);
        end
        cyc();
    endtask

    task automatic test_misaligned();
        pc_addr = 32'h22; fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        n_checks++;
        if ({fetch_err, imem_req_valid, disablepc, ir_valid} !== 4'b1010 || ir !== 32'h12345678) begin
            n_fail++;
            $display("FAIL misaligned: got err/rv/dpc/iv=%b ir=%h expected 1010 12345678", {fetch_err, imem_req_valid, disablepc, ir_valid}, ir);
        end
        cyc();
        n_checks++;
        if (fetch_err !== 1'b0 || busy !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_after: got err=%b busy=%b rv=%b expected 0 0 0", fetch_err, busy, imem_req_valid);
        end
    endtask

    // Start a fetch and stop at the first WAIT cycle.
    task automatic start_to_wait(input logic [31:0] a);
        pc_addr = a; fetch_req = 1'b1; imem_req_ready = 1'b1;
        cyc();
        fetch_req = 1'b0;
        cyc();
    endtask

    task automatic test_timeout();
        start_to_wait(32'h40);              // WAIT cycle 1
        for (int i = 2; i <= 15; i++) begin
            cyc();                          // WAIT cycle i
            n_checks++;
            if (busy !== 1'b1 || fetch_err !== 1'b0 || ir_valid !== 1'b0) begin
                n_fail++; $display("FAIL to_wait%0d: got busy=%b err=%b iv=%b expected 1 0 0", i, busy, fetch_err, ir_valid);
            end
        end
        cyc();                              // no response on cycle 15 -> ERR
        n_checks++;
        if (fetch_err !== 1'b1 || ir_valid !== 1'b0 || disablepc !== 1'b1 || ir !== 32'h12345678) begin
            n_fail++; $display("FAIL to_err: got err=%b iv=%b dpc=%b ir=%h expected 1 0 1 12345678", fetch_err, ir_valid, disablepc, ir);
        end
        cyc();
    endtask

    task automatic test_rsp_on_last();
        start_to_wait(32'h48);
        for (int i = 2; i <= 15; i++) cyc();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFEF00D;
        cyc();
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (ir_valid !== 1'b1 || fetch_err !== 1'b0 || ir !== 32'hCAFEF00D || disablepc !== 1'b0) begin
            n_fail++; $display("FAIL last_rsp: got iv=%b err=%b ir=%h dpc=%b expected 1 0 cafef00d 0", ir_valid, fetch_err, ir, disablepc);
        end
        cyc();
    endtask

    task automatic test_noise();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0BAD0;
        cyc();                              // response in IDLE
        n_checks++;
        if (ir !== 32'hCAFEF00D || busy !== 1'b0) begin
            n_fail++; $display("FAIL noise_idle: got ir=%h busy=%b expected cafef00d 0", ir, busy);
        end
        pc_addr = 32'h50; fetch_req = 1'b1; imem_req_ready = 1'b0;
        cyc();                              // REQ, response still asserted
        pc_addr = 32'h60;                   // fetch_req held high while busy
        cyc();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h50 || ir !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL noise_req: got rv=%b addr=%h ir=%h expected 1 00000050 cafef00d", imem_req_valid, imem_req_addr, ir);
        end
        fetch_req = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
        cyc();                              // -> WAIT
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000ABCD;
        cyc();
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (ir !== 32'h0000ABCD || ir_valid !== 1'b1) begin
            n_fail++; $display("FAIL noise_done: got ir=%h iv=%b expected 0000abcd 1", ir, ir_valid);
        end
    endtask

    task automatic test_back_to_back();
        cyc();                              // DONE -> IDLE
        pc_addr = 32'h70; fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h70) begin
            n_fail++; $display("FAIL b2b_req: got rv=%b addr=%h expected 1 00000070", imem_req_valid, imem_req_addr);
        end
        cyc();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11112222;
        cyc();
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (ir !== 32'h11112222 || ir_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done: got ir=%h iv=%b expected 11112222 1", ir, ir_valid);
        end
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        start_to_wait(32'h80);
        cyc();                              // WAIT cycle 2
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, disablepc, imem_req_valid, ir_valid, fetch_err} !== 5'b01000 || ir !== 32'h0 || imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got ctrl=%b ir=%h addr=%h expected 01000 0 0", {busy, disablepc, imem_req_valid, ir_valid, fetch_err}, ir, imem_req_addr);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (busy !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got busy=%b rv=%b expected 0 0", busy, imem_req_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_misaligned();
        test_timeout();
        test_rsp_on_last();
        test_noise();
        test_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
